// File: rtl/rv32i_types.sv
// rtl/rv32i_types.sv - shared RV32I types, including the data-memory responder state encoding
package rv32i_types;

  typedef logic [31:0] rv32i_word;
  typedef logic [3:0]  rv32i_mem_wmask;

  typedef enum bit [1:0] {DMEM_IDLE, DMEM_WAIT, DMEM_RESP} dmem_state_t;

  localparam int DMEM_MAX_LATENCY = 15;

endpackage

// File: rtl/dmem_sram.sv
// rtl/dmem_sram.sv - 2^ADDR_WIDTH x 32 word array, synchronous read, per-lane write, no reset
module dmem_sram #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rd_en,
  input  logic [3:0]            wr_en,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  logic [31:0] mem [0:(1 << ADDR_WIDTH) - 1];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (wr_en[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
    if (rd_en) rdata <= mem[addr];
  end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data-memory responder: request capture, latency FSM, fault checks
module dmem_responder
  import rv32i_types::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] mem_address,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_byte_enable,
  output logic [31:0] mem_rdata,
  output logic        mem_resp,
  output logic        mem_err,
  output logic        busy
);

  localparam logic [3:0] WAIT_LOAD = 4'(LATENCY - 1);

  dmem_state_t           state;
  logic [3:0]            cnt;
  logic [ADDR_WIDTH-1:0] cap_index;
  rv32i_word             cap_wdata;
  rv32i_mem_wmask        cap_be;
  logic                  cap_write;
  logic                  cap_fault;
  logic                  rdata_valid;

  logic                  in_idle;
  logic                  req;
  logic                  in_fault;
  logic                  cur_write;
  logic                  cur_fault;
  logic [ADDR_WIDTH-1:0] cur_index;
  rv32i_word             cur_wdata;
  rv32i_mem_wmask        cur_be;
  logic                  entering_resp;
  logic                  commit_ok;
  logic                  sram_rd;
  logic [3:0]            sram_we;
  rv32i_word             sram_q;
  logic                  unused_addr_bits;

  assign unused_addr_bits = ^mem_address[1:0];

  assign in_idle  = (state == DMEM_IDLE);
  assign req      = mem_read | mem_write;
  assign in_fault = (mem_read & mem_write) | (|(mem_address >> (ADDR_WIDTH + 2)));

  // With LATENCY=1 the commit edge is also the capture edge, so the live inputs feed it directly.
  assign cur_write = in_idle ? mem_write : cap_write;
  assign cur_fault = in_idle ? in_fault : cap_fault;
  assign cur_index = in_idle ? mem_address[ADDR_WIDTH+1:2] : cap_index;
  assign cur_wdata = in_idle ? mem_wdata : cap_wdata;
  assign cur_be    = in_idle ? mem_byte_enable : cap_be;

  assign entering_resp = (in_idle & req & (LATENCY == 1)) |
                         ((state == DMEM_WAIT) & (cnt <= 4'd1));
  assign commit_ok     = entering_resp & ~cur_fault;
  assign sram_rd       = commit_ok & ~cur_write;
  assign sram_we       = (commit_ok & cur_write) ? cur_be : 4'b0000;

  dmem_sram #(.ADDR_WIDTH(ADDR_WIDTH)) u_sram (
    .clk   (clk),
    .rd_en (sram_rd),
    .wr_en (sram_we),
    .addr  (cur_index),
    .wdata (cur_wdata),
    .rdata (sram_q)
  );

  // The array output has no reset, so a flag selects between it and zero.
  assign mem_rdata = rdata_valid ? sram_q : 32'h0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= DMEM_IDLE;
      cnt         <= 4'd0;
      cap_index   <= '0;
      cap_wdata   <= '0;
      cap_be      <= '0;
      cap_write   <= 1'b0;
      cap_fault   <= 1'b0;
      rdata_valid <= 1'b0;
      mem_resp    <= 1'b0;
      mem_err     <= 1'b0;
      busy        <= 1'b0;
    end else begin
      mem_resp <= 1'b0;
      mem_err  <= 1'b0;
      case (state)
        DMEM_IDLE: begin
          if (req) begin
            cap_index <= mem_address[ADDR_WIDTH+1:2];
            cap_wdata <= mem_wdata;
            cap_be    <= mem_byte_enable;
            cap_write <= mem_write;
            cap_fault <= in_fault;
            busy      <= 1'b1;
            if (LATENCY == 1) begin
              state    <= DMEM_RESP;
              mem_resp <= 1'b1;
              mem_err  <= in_fault;
            end else begin
              state <= DMEM_WAIT;
              cnt   <= WAIT_LOAD;
            end
          end
        end
        DMEM_WAIT: begin
          if (cnt <= 4'd1) begin
            cnt      <= 4'd0;
            state    <= DMEM_RESP;
            mem_resp <= 1'b1;
            mem_err  <= cap_fault;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DMEM_RESP: begin
          state <= DMEM_IDLE;
          busy  <= 1'b0;
        end
        default: state <= DMEM_IDLE;
      endcase
      if (sram_rd) rdata_valid <= 1'b1;
      else if (entering_resp && cur_fault) rdata_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed bench for dmem_responder at latencies 2, 1, 15 and 3
module tb_dmem_responder;

  localparam int LATS [4] = '{2, 1, 15, 3};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rd = 1'b0;
  logic        wr = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic [3:0]  be = 4'h0;
  logic [1:0]  sel = 2'd0;

  logic [3:0]  rd_g, wr_g;
  logic [3:0]  resp_v, err_v, busy_v;
  logic [31:0] rdata_v [4];

  int checks = 0;
  int errors = 0;

  assign rd_g = rd ? (4'b0001 << sel) : 4'b0000;
  assign wr_g = wr ? (4'b0001 << sel) : 4'b0000;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    dmem_responder #(.ADDR_WIDTH(10), .LATENCY(LATS[g])) u_dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .mem_read        (rd_g[g]),
      .mem_write       (wr_g[g]),
      .mem_address     (addr),
      .mem_wdata       (wdata),
      .mem_byte_enable (be),
      .mem_rdata       (rdata_v[g]),
      .mem_resp        (resp_v[g]),
      .mem_err         (err_v[g]),
      .busy            (busy_v[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drop();
    rd = 1'b0;
    wr = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge of the idle cycle after mem_resp, request still held.
  task automatic xact(input string tag, input logic r, input logic w, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] b, input int lat,
                      input logic exp_err, input logic chk_rd, input logic [31:0] exp_rd,
                      input logic scramble);
    int   n = 0;
    logic all_busy = 1'b1;
    rd = r; wr = w; addr = a; wdata = d; be = b;
    do begin
      @(negedge clk);
      n++;
      all_busy &= busy_v[sel];
      if (scramble && n == 1) begin
        addr  = 32'h40;
        wdata = 32'h0;
      end
    end while (!resp_v[sel] && n < 40);
    chk({tag, " latency"}, n, lat);
    chk({tag, " busy"}, {31'h0, all_busy}, 32'h1);
    chk({tag, " err"}, {31'h0, err_v[sel]}, {31'h0, exp_err});
    if (chk_rd) chk({tag, " rdata"}, rdata_v[sel], exp_rd);
    @(negedge clk);
    chk({tag, " idle"}, {30'h0, resp_v[sel], busy_v[sel]}, 32'h0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset resp", {28'h0, resp_v}, 32'h0);
    chk("reset err", {28'h0, err_v}, 32'h0);
    chk("reset busy", {28'h0, busy_v}, 32'h0);
    chk("reset rdata", rdata_v[0], 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    sel = 2'd0;
    xact("wr40", 0, 1, 32'h40, 32'h12345678, 4'hF, 2, 0, 0, 32'h0, 0); drop();
    xact("rd40", 1, 0, 32'h40, 32'h0, 4'hF, 2, 0, 1, 32'h12345678, 0); drop();
    xact("wrlane", 0, 1, 32'h40, 32'hAABBCCDD, 4'b0101, 2, 0, 0, 32'h0, 0); drop();
    xact("rdlane", 1, 0, 32'h40, 32'h0, 4'h0, 2, 0, 1, 32'h12BB56DD, 0); drop();
    xact("wrbe0", 0, 1, 32'h40, 32'hFFFFFFFF, 4'h0, 2, 0, 0, 32'h0, 0); drop();
    xact("rdbe0", 1, 0, 32'h40, 32'h0, 4'hF, 2, 0, 1, 32'h12BB56DD, 0); drop();
    xact("rdoor", 1, 0, 32'h1000, 32'h0, 4'hF, 2, 1, 1, 32'h0, 0); drop();
    xact("rdrestore", 1, 0, 32'h40, 32'h0, 4'hF, 2, 0, 1, 32'h12BB56DD, 0); drop();
    xact("rdwr", 1, 1, 32'h40, 32'h0, 4'hF, 2, 1, 1, 32'h0, 0); drop();
    xact("rdafterrdwr", 1, 0, 32'h40, 32'h0, 4'hF, 2, 0, 1, 32'h12BB56DD, 0); drop();
    xact("b2bwr", 0, 1, 32'h44, 32'h0BADF00D, 4'hF, 2, 0, 0, 32'h0, 1);
    xact("b2brd", 1, 0, 32'h44, 32'h0, 4'hF, 2, 0, 1, 32'h0BADF00D, 1); drop();
    xact("rd40final", 1, 0, 32'h40, 32'h0, 4'hF, 2, 0, 1, 32'h12BB56DD, 0); drop();

    sel = 2'd1;
    xact("l1wr", 0, 1, 32'h8, 32'hCAFEBABE, 4'hF, 1, 0, 0, 32'h0, 0);
    xact("l1rd", 1, 0, 32'h8, 32'h0, 4'hF, 1, 0, 1, 32'hCAFEBABE, 0); drop();

    sel = 2'd2;
    xact("l15wr", 0, 1, 32'hC, 32'h01020304, 4'hF, 15, 0, 0, 32'h0, 0); drop();
    xact("l15rd", 1, 0, 32'hC, 32'h0, 4'hF, 15, 0, 1, 32'h01020304, 0); drop();

    sel = 2'd3;
    xact("l3wr80", 0, 1, 32'h80, 32'h0, 4'hF, 3, 0, 0, 32'h0, 0); drop();
    xact("l3wr84", 0, 1, 32'h84, 32'h000055AA, 4'hF, 3, 0, 0, 32'h0, 0); drop();
    xact("l3rd84", 1, 0, 32'h84, 32'h0, 4'hF, 3, 0, 1, 32'h000055AA, 0); drop();
    rd = 1'b0; wr = 1'b1; addr = 32'h80; wdata = 32'hDEADBEEF; be = 4'hF;
    @(negedge clk);
    chk("rst pre busy", {31'h0, busy_v[3]}, 32'h1);
    rst_n = 1'b0;
    drop();
    #1;
    chk("rst mid flags", {29'h0, resp_v[3], busy_v[3], err_v[3]}, 32'h0);
    chk("rst mid rdata", rdata_v[3], 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    xact("l3rd80", 1, 0, 32'h80, 32'h0, 4'hF, 3, 0, 1, 32'h0, 0); drop();

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
